// File: rtl/fetch_unit.sv
// fetch_unit: front end of the 4-bit microcoded core.
// Holds the program counter, the fetch/execute phase flop, the fetched
// instruction byte and the carry/zero flags, and packs them into the
// 7-bit microcode address {instr, C, Z, phase} for the decode ROM.
// The decode ROM's PC and flag strobes come back in here, closing the loop.
module fetch_unit #(
    parameter int PC_W = 12
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            enable,
    input  logic            inc_pc,
    input  logic            load_pc,
    input  logic [PC_W-1:0] load_addr,
    input  logic            load_flags,
    input  logic            c_in,
    input  logic            z_in,
    input  logic [7:0]      prog_byte,
    output logic [PC_W-1:0] pc,
    output logic            phase,
    output logic [3:0]      instr,
    output logic [3:0]      oprnd,
    output logic            c_flag,
    output logic            z_flag,
    output logic [6:0]      decode_addr
);

    // Two-phase instruction cycle: FETCH latches the program byte,
    // EXECUTE presents opcode plus flags to the decode ROM.
    typedef enum logic {
        FETCH   = 1'b0,
        EXECUTE = 1'b1
    } phase_t;

    phase_t          phase_state;
    phase_t          phase_next;

    logic [PC_W-1:0] pc_reg;
    logic [PC_W-1:0] pc_next;

    logic [7:0]      fetch_reg;
    logic [7:0]      fetch_next;

    logic            c_reg;
    logic            c_next;
    logic            z_reg;
    logic            z_next;

    // State register for every piece of front-end state; reset wins over enable.
    always_ff @(posedge clock) begin
        if (reset) begin
            phase_state <= FETCH;
            pc_reg      <= '0;
            fetch_reg   <= 8'h00;
            c_reg       <= 1'b0;
            z_reg       <= 1'b0;
        end else begin
            phase_state <= phase_next;
            pc_reg      <= pc_next;
            fetch_reg   <= fetch_next;
            c_reg       <= c_next;
            z_reg       <= z_next;
        end
    end

    // Phase toggles once per enabled cycle and otherwise holds.
    always_comb begin
        phase_next = phase_state;
        if (enable) begin
            case (phase_state)
                FETCH:   phase_next = EXECUTE;
                EXECUTE: phase_next = FETCH;
                default: phase_next = FETCH;
            endcase
        end
    end

    // Jump load beats increment; increment wraps naturally at 2^PC_W.
    always_comb begin
        pc_next = pc_reg;
        if (enable) begin
            if (load_pc) begin
                pc_next = load_addr;
            end else if (inc_pc) begin
                pc_next = pc_reg + PC_W'(1);
            end
        end
    end

    // Program byte is captured only during an enabled FETCH cycle.
    always_comb begin
        fetch_next = fetch_reg;
        if (enable && (phase_state == FETCH)) begin
            fetch_next = prog_byte;
        end
    end

    // Flags follow the ALU whenever decode strobes them, in either phase.
    always_comb begin
        c_next = c_reg;
        z_next = z_reg;
        if (enable && load_flags) begin
            c_next = c_in;
            z_next = z_in;
        end
    end

    assign pc          = pc_reg;
    assign phase       = phase_state;
    assign instr       = fetch_reg[7:4];
    assign oprnd       = fetch_reg[3:0];
    assign c_flag      = c_reg;
    assign z_flag      = z_reg;
    assign decode_addr = {fetch_reg[7:4], c_reg, z_reg, phase_state};

endmodule
